// File: rtl/hash_cmp_pkg.sv
// Shared types and constants for the sequential hash-vs-target checker.
// Saturating hit-counter helper lives here so the top stays focused on the FSM.
package hash_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int                   HIT_CNT_W   = 16;
  localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = {HIT_CNT_W{1'b1}};

  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (v == HIT_CNT_MAX) ? v : v + HIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/hash_target_checker_if.sv
// Hash stream handshake (SHA core -> checker) and the per-hash result pulse.
interface hash_target_checker_if #(
  parameter int WIDTH   = 256,
  parameter int NONCE_W = 32
) ();
  logic               hash_valid;
  logic               hash_ready;
  logic [WIDTH-1:0]   hash_in;
  logic [NONCE_W-1:0] nonce_in;
  logic               result_valid;
  logic               result_hit;

  modport master (
    output hash_valid, hash_in, nonce_in,
    input  hash_ready, result_valid, result_hit
  );

  modport slave (
    input  hash_valid, hash_in, nonce_in,
    output hash_ready, result_valid, result_hit
  );
endinterface

// File: rtl/chunk_compare.sv
// Combinational CHUNK-wide unsigned three-way compare (lt / eq; gt is implied).
module chunk_compare #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// File: rtl/hash_target_checker.sv
// Sequential hash < target (or <=) checker: one CHUNK per cycle from the MSB,
// early exit on the first differing chunk, with sticky first-hit nonce and hit count.
module hash_target_checker
  import hash_cmp_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int CHUNK   = 32,
  parameter int NONCE_W = 32,
  parameter bit LE_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  hash_target_checker_if.slave hs,
  input  logic                 target_load,
  input  logic [WIDTH-1:0]     target_in,
  input  logic                 clear_found,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic [HIT_CNT_W-1:0] hit_count
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int SEL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_width_chk
    $error("hash_target_checker: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [WIDTH-1:0]     work_hash_q, work_hash_d;
  logic [WIDTH-1:0]     work_tgt_q, work_tgt_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic                 hit_q, hit_d;
  logic                 res_vld_q, res_vld_d;
  logic                 ready_q, ready_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic [SEL_W-1:0]     sel_lo;
  logic [CHUNK-1:0]     hash_chunk, tgt_chunk;
  logic                 c_lt, c_eq;

  // Chunk 0 is the most significant slice, so the low bit offset counts down.
  always_comb begin
    sel_lo     = SEL_W'((N_CHUNKS - 1 - int'(idx_q)) * CHUNK);
    hash_chunk = work_hash_q[sel_lo +: CHUNK];
    tgt_chunk  = work_tgt_q[sel_lo +: CHUNK];
  end

  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a  (hash_chunk),
    .b  (tgt_chunk),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    target_d      = target_load ? target_in : target_q;
    work_hash_d   = work_hash_q;
    work_tgt_d    = work_tgt_q;
    nonce_d       = nonce_q;
    hit_d         = hit_q;
    res_vld_d     = 1'b0;
    ready_d       = ready_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    hit_cnt_d     = hit_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hs.hash_valid) begin
          // target_d already carries a same-edge target_load (forwarding).
          work_hash_d = hs.hash_in;
          work_tgt_d  = target_d;
          nonce_d     = hs.nonce_in;
          idx_d       = '0;
          ready_d     = 1'b0;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!c_eq) begin
          hit_d     = c_lt;
          res_vld_d = 1'b1;
          state_d   = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          hit_d     = LE_MODE;
          res_vld_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // A hit retiring on this edge beats a simultaneous clear_found.
    if (state_q == ST_DONE && hit_q) begin
      if (clear_found) begin
        found_d       = 1'b1;
        found_nonce_d = nonce_q;
        hit_cnt_d     = HIT_CNT_W'(1);
      end else begin
        if (!found_q) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
        end
        hit_cnt_d = sat_inc(hit_cnt_q);
      end
    end else if (clear_found) begin
      found_d       = 1'b0;
      found_nonce_d = '0;
      hit_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      target_q      <= '0;
      work_hash_q   <= '0;
      work_tgt_q    <= '0;
      nonce_q       <= '0;
      hit_q         <= 1'b0;
      res_vld_q     <= 1'b0;
      ready_q       <= 1'b1;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      hit_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      target_q      <= target_d;
      work_hash_q   <= work_hash_d;
      work_tgt_q    <= work_tgt_d;
      nonce_q       <= nonce_d;
      hit_q         <= hit_d;
      res_vld_q     <= res_vld_d;
      ready_q       <= ready_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      hit_cnt_q     <= hit_cnt_d;
    end
  end

  assign hs.hash_ready   = ready_q;
  assign hs.result_valid = res_vld_q;
  assign hs.result_hit   = hit_q;
  assign found           = found_q;
  assign found_nonce     = found_nonce_q;
  assign hit_count       = hit_cnt_q;

endmodule

// File: tb/tb_hash_target_checker.sv
// Drives an LE_MODE=0 and an LE_MODE=1 checker with identical stimulus and
// compares both against a reference built on plain wide-integer compares.
module tb_hash_target_checker;
  localparam int W  = 256;
  localparam int C  = 32;
  localparam int NW = 32;
  localparam int N  = W / C;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic                 target_load = 1'b0;
  logic [W-1:0]         target_in = '0;
  logic                 clear_found = 1'b0;
  logic [1:0]           found;
  logic [1:0][NW-1:0]   fnonce;
  logic [1:0][15:0]     hcnt;

  hash_target_checker_if #(.WIDTH(W), .NONCE_W(NW)) if0 ();
  hash_target_checker_if #(.WIDTH(W), .NONCE_W(NW)) if1 ();

  hash_target_checker #(.WIDTH(W), .CHUNK(C), .NONCE_W(NW), .LE_MODE(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .hs(if0), .target_load(target_load), .target_in(target_in),
    .clear_found(clear_found), .found(found[0]), .found_nonce(fnonce[0]), .hit_count(hcnt[0]));

  hash_target_checker #(.WIDTH(W), .CHUNK(C), .NONCE_W(NW), .LE_MODE(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .hs(if1), .target_load(target_load), .target_in(target_in),
    .clear_found(clear_found), .found(found[1]), .found_nonce(fnonce[1]), .hit_count(hcnt[1]));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // reference state
  bit [1:0]     m_found;
  logic [NW-1:0] m_nonce [2];
  int           m_cnt [2];
  logic [W-1:0] m_target;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_diff(input logic [W-1:0] h, input logic [W-1:0] t);
    logic [W-1:0] x;
    x = h ^ t;
    for (int b = W - 1; b >= 0; b--)
      if (x[b]) return (W - 1 - b) / C;
    return N - 1;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] h, input logic [NW-1:0] n);
    if0.hash_valid = v; if1.hash_valid = v;
    if0.hash_in    = h; if1.hash_in    = h;
    if0.nonce_in   = n; if1.nonce_in   = n;
  endtask

  task automatic check_status(input string tag);
    chk({tag, " found"},  W'(found),  W'(m_found));
    chk({tag, " nonce0"}, W'(fnonce[0]), W'(m_nonce[0]));
    chk({tag, " nonce1"}, W'(fnonce[1]), W'(m_nonce[1]));
    chk({tag, " cnt0"},   W'(hcnt[0]), W'(m_cnt[0]));
    chk({tag, " cnt1"},   W'(hcnt[1]), W'(m_cnt[1]));
  endtask

  task automatic model_reset();
    m_found = '0; m_target = '0;
    for (int m = 0; m < 2; m++) begin m_nonce[m] = '0; m_cnt[m] = 0; end
  endtask

  // One transaction, entered and left at a negedge with both DUTs idle.
  task automatic xfer(input string tag, input logic [W-1:0] h, input logic [NW-1:0] nonce,
                      input bit load_now, input logic [W-1:0] new_t,
                      input bit mid_load, input logic [W-1:0] mid_t, input bit clr_done);
    logic [W-1:0] eff;
    bit [1:0] hit;
    int j, k, rl;
    chk({tag, " ready"}, W'({if1.hash_ready, if0.hash_ready}), W'(2'b11));
    eff = load_now ? new_t : m_target;
    if (load_now) begin target_load = 1'b1; target_in = new_t; m_target = new_t; end
    hit[0] = (h < eff);
    hit[1] = (h <= eff);
    j = first_diff(h, eff);
    drive(1'b1, h, nonce);
    @(posedge clk); @(negedge clk);
    drive(1'b0, '0, '0);
    target_load = 1'b0;
    rl = (!if0.hash_ready && !if1.hash_ready) ? 1 : 0;
    if (mid_load) begin target_load = 1'b1; target_in = mid_t; m_target = mid_t; end
    k = 0;
    do begin
      @(posedge clk); @(negedge clk);
      target_load = 1'b0;
      k++;
      if (!if0.hash_ready && !if1.hash_ready) rl++;
    end while (!if0.result_valid && k < N + 4);
    chk({tag, " latency"}, W'(k), W'(j + 1));
    chk({tag, " valid"}, W'({if1.result_valid, if0.result_valid}), W'(2'b11));
    chk({tag, " hit"}, W'({if1.result_hit, if0.result_hit}), W'(hit));
    chk({tag, " busy"}, W'(rl), W'(j + 2));
    clear_found = clr_done;
    @(posedge clk); @(negedge clk);
    clear_found = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (hit[m]) begin
        if (clr_done) begin
          m_found[m] = 1'b1; m_nonce[m] = nonce; m_cnt[m] = 1;
        end else begin
          if (!m_found[m]) begin m_found[m] = 1'b1; m_nonce[m] = nonce; end
          if (m_cnt[m] < 65535) m_cnt[m]++;
        end
      end else if (clr_done) begin
        m_found[m] = 1'b0; m_nonce[m] = '0; m_cnt[m] = 0;
      end
    end
    check_status(tag);
    chk({tag, " pulse"}, W'({if1.result_valid, if0.result_valid}), W'(2'b00));
    chk({tag, " held"}, W'({if1.result_hit, if0.result_hit}), W'(hit));
  endtask

  task automatic clear_only(input string tag);
    clear_found = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_found = 1'b0;
    m_found = '0;
    for (int m = 0; m < 2; m++) begin m_nonce[m] = '0; m_cnt[m] = 0; end
    check_status(tag);
  endtask

  initial begin
    logic [W-1:0] t, h, tx;
    bit seen;
    drive(1'b0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst ready", W'({if1.hash_ready, if0.hash_ready}), W'(2'b11));
    chk("rst valid", W'({if1.result_valid, if0.result_valid}), W'(2'b00));
    chk("rst hit", W'({if1.result_hit, if0.result_hit}), W'(2'b00));
    check_status("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // MSB-set target, tiny hash: decided in chunk 0
    t = '0; t[W-1] = 1'b1;
    xfer("first", W'(1), 32'hA5, 1'b1, t, 1'b0, '0, 1'b0);

    // exact equality walks all chunks
    t = {32'h0, {(W-32){1'b1}}};
    xfer("equal", t, 32'h1, 1'b1, t, 1'b0, '0, 1'b0);

    // only chunk 3 differs, hash larger
    t = {N{32'h1234_5678}};
    h = t; h[W-1-3*C -: C] = 32'h1234_5679;
    xfer("chunk3", h, 32'h3, 1'b1, t, 1'b0, '0, 1'b0);

    clear_only("clr0");
    t = '0; t[W-1] = 1'b1;
    xfer("hit7", W'(5), 32'd7, 1'b1, t, 1'b0, '0, 1'b0);
    xfer("hit9", W'(5), 32'd9, 1'b0, '0, 1'b0, '0, 1'b0);
    clear_only("clr1");
    xfer("hit11clr", W'(5), 32'd11, 1'b0, '0, 1'b0, '0, 1'b1);

    // reload mid-compare must not disturb the in-flight hash
    xfer("midload", W'(2), 32'd21, 1'b0, '0, 1'b1, '0, 1'b0);
    // reload on the accept edge is forwarded
    xfer("fwdload", W'(2), 32'd22, 1'b1, W'(3), 1'b0, '0, 1'b0);

    // reset in the middle of a long compare
    drive(1'b1, W'(3), 32'd99);
    @(posedge clk); @(negedge clk);
    drive(1'b0, '0, '0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("pre-rst busy", W'({if1.hash_ready, if0.hash_ready}), W'(2'b00));
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst ready", W'({if1.hash_ready, if0.hash_ready}), W'(2'b11));
    chk("midrst valid", W'({if1.result_valid, if0.result_valid}), W'(2'b00));
    chk("midrst hit", W'({if1.result_hit, if0.result_hit}), W'(2'b00));
    check_status("midrst");
    seen = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) begin @(negedge clk); seen |= (if0.result_valid | if1.result_valid); end
    chk("midrst no pulse", W'(seen), W'(1'b0));
    // target back at 0: hash 0 is equal
    xfer("rst target", '0, 32'd50, 1'b0, '0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      int p, gap;
      bit ld_now, mid, clr;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int c = 0; c < N; c++) tx[W-1-c*C -: C] = $urandom;
      t = m_target;
      ld_now = 1'b0;
      gap = $urandom_range(0, 3);
      if (gap == 0) begin
        t = tx;
        target_load = 1'b1; target_in = tx;
        @(posedge clk); @(negedge clk);
        target_load = 1'b0; m_target = tx;
      end else if (gap == 1) begin
        t = tx; ld_now = 1'b1;
      end
      p = $urandom_range(0, N);
      h = t;
      for (int c = p; c < N; c++) h[W-1-c*C -: C] = $urandom;
      mid = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < N; c++) tx[W-1-c*C -: C] = $urandom;
      xfer("rand", h, NW'($urandom), ld_now, t, mid, tx, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
